// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: opcode and memory handshake in,
// datapath controls and status out.
interface multicycle_controller_if;
    logic [5:0]  op;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic [3:0]  state;
    logic        error;
    logic [15:0] instr_count;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, error, instr_count
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, error, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS-style datapath (R, LW, SW, BEQ, J)
// with memory wait states, a wait-state watchdog and a fetch counter.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset_n,
    multicycle_controller_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ERROR     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [3:0] TIMEOUT_CODE = 4'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [5:0]  op_reg;
    logic [3:0]  wait_reg, wait_next;
    logic [15:0] count_reg;
    logic        in_wait;
    logic        timed_out;

    assign in_wait   = (state_reg == FETCH) || (state_reg == MEM_READ) || (state_reg == MEM_WRITE);
    assign timed_out = (TIMEOUT != 0) && (wait_reg == TIMEOUT_CODE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            op_reg    <= 6'd0;
            wait_reg  <= 4'd0;
            count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == DECODE)
                op_reg <= bus.op;
            if (state_reg == FETCH && state_next == DECODE)
                count_reg <= count_reg + 16'd1;
        end
    end

    // mem_ready wins over the watchdog in every wait state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (bus.mem_ready)  state_next = DECODE;
                else if (timed_out) state_next = ERROR;
            end
            DECODE: begin
                case (bus.op)
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_LW, OP_SW: state_next = MEM_ADDR;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    default:      state_next = ERROR;
                endcase
            end
            MEM_ADDR: begin
                if (op_reg == OP_LW)      state_next = MEM_READ;
                else if (op_reg == OP_SW) state_next = MEM_WRITE;
                else                      state_next = ERROR;
            end
            MEM_READ: begin
                if (bus.mem_ready)  state_next = MEM_WB;
                else if (timed_out) state_next = ERROR;
            end
            MEM_WRITE: begin
                if (bus.mem_ready)  state_next = FETCH;
                else if (timed_out) state_next = ERROR;
            end
            MEM_WB, R_WB, BRANCH, JUMP: state_next = FETCH;
            EXECUTE:                    state_next = R_WB;
            ERROR:                      state_next = ERROR;
            default:                    state_next = ERROR;
        endcase
    end

    // Count only while sitting in the same wait state; any exit or ready clears it
    always_comb begin
        wait_next = 4'd0;
        if (in_wait && !bus.mem_ready && state_next == state_reg)
            wait_next = 4'(wait_reg + 4'd1);
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        case (state_reg)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                // write enables stay low while reset is held
                bus.ir_write  = bus.mem_ready && reset_n;
                bus.pc_write  = bus.mem_ready && reset_n;
            end
            DECODE:   bus.alu_src_b = 2'b11;
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            R_WB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.state       = state_reg;
    assign bus.error       = (state_reg == ERROR);
    assign bus.instr_count = count_reg;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the number of consecutive mem_ready-low wait cycles before an error (range 1..15; 0 disables the timeout).
REQ-002 The block SHALL have these ports:
- clock  input  1  single clock, all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- op  input  6  opcode field from the instruction register
- mem_ready  input  1  memory completes the current read or write this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls
- alu_src_b, alu_op, pc_source  output  2 each  datapath mux and ALU controls
- state  output  4  current state code
- error  output  1  controller halted
- instr_count  output  16  count of completed fetches

Function
REQ-003 The block SHALL be a Moore FSM with codes FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ERROR=15; codes 10-14 SHALL go to ERROR on the next edge.
REQ-004 The block SHALL latch op into an internal register on the DECODE cycle; later transitions SHALL use the latched value, not the live op.
REQ-005 DECODE SHALL branch on op: 000000->EXECUTE, 100011 or 101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, any other value->ERROR.
REQ-006 The fixed transitions SHALL be: MEM_ADDR->MEM_READ (LW) or MEM_WRITE (SW); MEM_WB, R_WB, BRANCH, JUMP->FETCH; EXECUTE->R_WB.
REQ-007 FETCH, MEM_READ and MEM_WRITE SHALL be wait states, held while mem_ready=0 and left on the first edge with mem_ready=1: FETCH->DECODE, MEM_READ->MEM_WB, MEM_WRITE->FETCH.
REQ-008 Each wait state SHALL count consecutive mem_ready=0 cycles from 0, clearing the count on entry; when the count reaches TIMEOUT the next state SHALL be ERROR; mem_ready=1 on any cycle SHALL take priority over the timeout.
REQ-009 In ERROR all controls SHALL be 0 and error=1; only reset SHALL exit ERROR.
REQ-010 Controls SHALL be decoded from state, with every unlisted control 0:
- FETCH: mem_read=1, alu_src_b=01; ir_write=1 and pc_write=1 only while mem_ready=1.
- DECODE: alu_src_b=11.
- MEM_ADDR: alu_src_a=1, alu_src_b=10.
- MEM_READ: mem_read=1, i_or_d=1.
- MEM_WB: reg_write=1, mem_to_reg=1.
- MEM_WRITE: mem_write=1, i_or_d=1.
- EXECUTE: alu_src_a=1, alu_op=10.
- R_WB: reg_dst=1, reg_write=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
REQ-011 instr_count SHALL increment by 1 on each FETCH->DECODE edge, wrap from 0xFFFF to 0x0000, and hold in ERROR.
REQ-012 Latency SHALL be, in cycles with zero memory wait: R=4, LW=5, SW=4, BEQ=3, J=3; each wait cycle SHALL add 1.

Reset
REQ-013 reset_n=0 SHALL, asynchronously, set the state to FETCH, clear the latched op, the wait count, error and instr_count to 0, and drive all controls to 0 except the FETCH decodes (mem_read=1, alu_src_b=01).
REQ-014 Reset asserted mid-instruction, including during a wait or in ERROR, SHALL abandon the instruction; the first rising edge after reset_n=1 SHALL evaluate FETCH.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- mem_ready=1 always, op=000000 -> states 0,1,6,7,0; reg_dst=reg_write=1 in state 7; instr_count=1.
- op=100011, mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; mem_read=i_or_d=1 throughout state 3.
- op=101011 then op=000010 back-to-back -> states 0,1,2,5,0,1,9,0; pc_write=1 and pc_source=10 in state 9; instr_count=2.
- op=111111 at DECODE -> state=15, error=1, all controls 0, held until reset_n=0.
- mem_ready=0 held in FETCH with TIMEOUT=15 -> ERROR on the 16th edge; mem_ready=1 on the 15th edge instead -> DECODE.
- reset_n pulsed low in state 3 -> state=0, instr_count=0, error=0 immediately, without waiting for a clock edge.
